// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
//   Registered, valid/ready handshaked ALU with an iterative shift-add
//   multiplier. One operation in flight at a time. Non-MUL operations
//   present their result one cycle after acceptance; MUL presents after
//   WIDTH+1 cycles.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 8)
//   MUL_EN  1 enables the iterative MUL; 0 treats the MUL opcode as reserved
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands/opcode valid
//   in_ready   operation accepted this cycle when in_valid is also high
//   a, b       operands
//   op         operation select (4 bits)
//   out_valid  result/flags valid
//   out_ready  consumer accepts result this cycle
//   result     registered result
//   zero       result == 0
//   negative   result MSB
//   carry      ADD carry-out / SUB no-borrow, 0 otherwise
//   overflow   ADD/SUB signed overflow, 0 otherwise
//   busy       high while the multiplier is iterating
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             negative,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);

    localparam int SHW = $clog2(WIDTH);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;

    // Low 3 bits of ADD..SRA keep the legacy 3-bit encoding.
    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110;
    localparam logic [3:0] OP_SRA  = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;

    logic [0:0]       state;
    logic             accept;
    logic             is_mul;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;

    // Multiplier working registers.
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [SHW-1:0]   bit_cnt;
    logic [WIDTH-1:0] acc_next;
    logic             mul_done;

    // A new op is only taken when idle and the output slot is empty or
    // retiring this same cycle, so a held result is never overwritten.
    assign in_ready = !rst && (state == S_IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = MUL_EN && (op == OP_MUL);

    // One extra bit captures carry-out (ADD) and borrow (SUB).
    assign sum   = {1'b0, a} + {1'b0, b};
    assign diff  = {1'b0, a} - {1'b0, b};
    assign shamt = b[SHW-1:0];

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the case leaves a value unassigned (no latch).
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                // Same-sign operands producing an opposite-sign result.
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                // Borrow out of the top bit means a < b; carry is its inverse.
                alu_c   = !diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = $signed(a) >>> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            // MUL (handled by the iterative path, or reserved when disabled)
            // and 1011-1111 all produce zero here.
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: add the multiplicand when the current multiplier
    // bit is set. Only the low WIDTH bits are kept.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign mul_done = (bit_cnt == SHW'(WIDTH - 1));

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            carry     <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            // Retire the current result; a new load below may set it again.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state <= S_MUL;
                        end else begin
                            result    <= alu_res;
                            carry     <= alu_c;
                            overflow  <= alu_v;
                            out_valid <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    if (mul_done) begin
                        result    <= acc_next;
                        carry     <= 1'b0;
                        overflow  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // NOTE: the multiplier datapath has no reset; it is fully loaded on every
    // MUL accept and its contents are only observed after that load. A reset
    // mid-multiply returns the FSM to IDLE, so the partial product is dropped.
    always_ff @(posedge clk) begin
        if (state == S_IDLE) begin
            if (accept && is_mul) begin
                mcand   <= a;
                mplier  <= b;
                acc     <= '0;
                bit_cnt <= '0;
            end
        end else begin
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            acc     <= acc_next;
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign zero     = (result == '0);
    assign negative = result[WIDTH-1];
    assign busy     = (state == S_MUL);

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
//   Directed bench for alu_pipe (WIDTH=32, MUL_EN=1). Expected results come
//   from a behavioural model, are queued when an operation is accepted and
//   are compared when the DUT hands a result to the consumer.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -SMAX - 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         negative;
    logic         carry;
    logic         overflow;
    logic         busy;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         n;
        logic         c;
        logic         v;
    } exp_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   op;
    } vec_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fails   = 0;

    vec_t vecs [17] = '{
        '{32'd5,        32'd3,        4'b0000},  // ADD small
        '{32'hFFFFFFFF, 32'd1,        4'b0000},  // ADD carry, zero
        '{32'h7FFFFFFF, 32'd1,        4'b0000},  // ADD signed overflow
        '{32'd3,        32'd5,        4'b0001},  // SUB borrow
        '{32'd5,        32'd3,        4'b0001},  // SUB no borrow
        '{32'h80000000, 32'd1,        4'b0001},  // SUB signed overflow
        '{32'd7,        32'd7,        4'b0001},  // SUB equal -> zero, carry
        '{32'hF0F0F0F0, 32'hFF00FF00, 4'b0010},  // AND
        '{32'hF0F0F0F0, 32'h0F0F0000, 4'b0011},  // OR
        '{32'hAAAA5555, 32'hFFFF0000, 4'b0100},  // XOR
        '{32'd1,        32'h00000021, 4'b0101},  // SLL upper b bits ignored
        '{32'h80000000, 32'd4,        4'b0110},  // SRL
        '{32'h80000000, 32'h00000024, 4'b0111},  // SRA shift 4
        '{32'hFFFFFFFF, 32'd1,        4'b1000},  // SLT signed
        '{32'hFFFFFFFF, 32'd1,        4'b1001},  // SLTU
        '{32'd5,        32'd3,        4'b1011},  // reserved
        '{32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1111}   // reserved
    };

    always #5 clk = ~clk;

    alu_pipe #(
        .WIDTH  (W),
        .MUL_EN (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .negative  (negative),
        .carry     (carry),
        .overflow  (overflow),
        .busy      (busy)
    );

    // Behavioural reference: widened unsigned math for carries, 64-bit
    // signed math for overflow.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic [3:0] o);
        exp_t        e;
        logic [63:0] wide;
        longint      sx;
        longint      sy;
        longint      ss;
        int          sh;
        e  = '0;
        sx = $signed(x);
        sy = $signed(y);
        sh = int'(y[4:0]);
        case (o)
            4'b0000: begin
                wide  = {32'b0, x} + {32'b0, y};
                e.res = wide[31:0];
                e.c   = wide[32];
                ss    = sx + sy;
                e.v   = (ss > SMAX) || (ss < SMIN);
            end
            4'b0001: begin
                e.res = x - y;
                e.c   = (x >= y);
                ss    = sx - sy;
                e.v   = (ss > SMAX) || (ss < SMIN);
            end
            4'b0010: e.res = x & y;
            4'b0011: e.res = x | y;
            4'b0100: e.res = x ^ y;
            4'b0101: e.res = x << sh;
            4'b0110: e.res = x >> sh;
            4'b0111: e.res = $signed(x) >>> sh;
            4'b1000: e.res = (sx < sy) ? 32'd1 : 32'd0;
            4'b1001: e.res = (x < y) ? 32'd1 : 32'd0;
            4'b1010: begin
                wide  = {32'b0, x} * {32'b0, y};
                e.res = wide[31:0];
            end
            default: e.res = '0;
        endcase
        e.z = (e.res == 32'd0);
        e.n = e.res[31];
        return e;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] expv);
        n_asserts++;
        assert (obs === expv)
        else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Compare any result retiring at the coming edge, then advance one cycle.
    // Inputs and outputs are both sampled mid-cycle, 1 time unit after the edge.
    task automatic tick();
        exp_t e;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("spurious_out_valid", {31'b0, out_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("result",   result,           e.res);
                check("zero",     {31'b0, zero},     {31'b0, e.z});
                check("negative", {31'b0, negative}, {31'b0, e.n});
                check("carry",    {31'b0, carry},    {31'b0, e.c});
                check("overflow", {31'b0, overflow}, {31'b0, e.v});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic [3:0] o);
        int n;
        n        = 0;
        in_valid = 1'b1;
        a        = x;
        b        = y;
        op       = o;
        #0;
        while (!in_ready && n < 100) begin
            tick();
            n++;
        end
        check("issue_in_ready", {31'b0, in_ready}, 32'd1);
        sb.push_back(model(x, y, o));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            tick();
            n++;
        end
        check("drain_pending", sb.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = '0;
        out_ready = 1'b1;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_in_ready",  {31'b0, in_ready},  32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_result",    result,             32'd0);
        check("rst_zero",      {31'b0, zero},      32'd1);
        check("rst_negative",  {31'b0, negative},  32'd0);
        check("rst_carry",     {31'b0, carry},     32'd0);
        check("rst_overflow",  {31'b0, overflow},  32'd0);
        check("rst_busy",      {31'b0, busy},      32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Latency 1 for a single ADD
        issue(32'd5, 32'd3, 4'b0000);
        check("add_latency_out_valid", {31'b0, out_valid}, 32'd1);
        drain();
        check("out_valid_drops", {31'b0, out_valid}, 32'd0);

        // One op at a time through every opcode class
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].op);
            drain();
        end

        // Back-to-back: one accept per cycle with out_ready held high
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            a        = 32'h11111111 * (i + 1);
            b        = 32'h0F0F0F0F + i;
            op       = (i % 2 == 0) ? 4'b0000 : 4'b0001;
            #0;
            check("burst_in_ready", {31'b0, in_ready}, 32'd1);
            sb.push_back(model(a, b, op));
            tick();
        end
        in_valid = 1'b0;
        drain();

        // Iterative MUL: busy for WIDTH cycles, result at accept+WIDTH+1
        in_valid = 1'b1;
        a        = 32'd1234;
        b        = 32'd5678;
        op       = 4'b1010;
        #0;
        check("mul_accept_ready", {31'b0, in_ready}, 32'd1);
        sb.push_back(model(a, b, op));
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            check("mul_busy",      {31'b0, busy},      32'd1);
            check("mul_in_ready",  {31'b0, in_ready},  32'd0);
            check("mul_out_valid", {31'b0, out_valid}, 32'd0);
            tick();
        end
        check("mul_done_out_valid", {31'b0, out_valid}, 32'd1);
        check("mul_done_busy",      {31'b0, busy},      32'd0);
        check("mul_result_const",   result,             32'd7006652);
        drain();

        issue(32'h00010000, 32'h00010000, 4'b1010);
        drain();
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 4'b1010);
        drain();

        // Backpressure: result held, nothing accepted, then drained in order
        out_ready = 1'b0;
        issue(32'd100, 32'd23, 4'b0000);
        in_valid = 1'b1;
        a        = 32'h7FFFFFFF;
        b        = 32'd2;
        op       = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            check("bp_in_ready",  {31'b0, in_ready},  32'd0);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
            check("bp_result",    result,             sb[0].res);
            check("bp_carry",     {31'b0, carry},     {31'b0, sb[0].c});
            tick();
        end
        out_ready = 1'b1;
        #0;
        check("bp_release_in_ready", {31'b0, in_ready}, 32'd1);
        sb.push_back(model(a, b, op));
        tick();
        a = 32'hFFFFFFF0;
        b = 32'h00000020;
        #0;
        check("bp_in_ready_3", {31'b0, in_ready}, 32'd1);
        sb.push_back(model(a, b, op));
        tick();
        a = 32'd9;
        b = 32'd9;
        #0;
        check("bp_in_ready_4", {31'b0, in_ready}, 32'd1);
        sb.push_back(model(a, b, op));
        tick();
        in_valid = 1'b0;
        check("bp_out_valid_stream", {31'b0, out_valid}, 32'd1);
        drain();

        // Reset in the middle of a multiply
        issue(32'd7, 32'd9, 4'b1010);
        for (int i = 0; i < 10; i++) begin
            tick();
        end
        check("abort_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_busy",      {31'b0, busy},      32'd0);
        check("abort_result",    result,             32'd0);
        check("abort_zero",      {31'b0, zero},      32'd1);
        check("abort_in_ready",  {31'b0, in_ready},  32'd0);
        sb.delete();
        rst = 1'b0;
        #1;
        check("abort_in_ready_after", {31'b0, in_ready}, 32'd1);
        issue(32'd2, 32'd2, 4'b0000);
        check("abort_add_result", result, 32'd4);
        drain();
        // Long enough for an un-aborted multiply to surface as a spurious result
        for (int i = 0; i < 40; i++) begin
            tick();
        end
        check("abort_no_late_result", {31'b0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_asserts, n_fails);
        $finish;
    end

endmodule
